pipe_collision_scorer: RTL

//  Game-state stage sitting between the bird/pipe motion logic and pipeAnimations-style

---
 rtl/pipe_collision_scorer_if.sv | 29 ++
 rtl/pipe_collision_scorer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pipe_collision_scorer_if.sv
// Game-state bus between motion logic and the collision/score stage.
// HIGH_SCORE_EN adds the hiScore output.
interface pipe_collision_scorer_if;
  logic        start;
  logic [9:0]  pointY;
  logic [29:0] pipeX;
  logic [29:0] gapY;
  logic [9:0]  gapHalf;
  logic [2:0]  pipeEn;
  logic [9:0]  score;
  logic        running;
  logic        frozen;
  logic        gameOver;
  logic        hitPulse;
  logic        passPulse;
`ifdef HIGH_SCORE_EN
  logic [9:0]  hiScore;

  modport master (output start, pointY, pipeX, gapY, gapHalf, pipeEn,
                  input  score, running, frozen, gameOver, hitPulse, passPulse, hiScore);
  modport slave  (input  start, pointY, pipeX, gapY, gapHalf, pipeEn,
                  output score, running, frozen, gameOver, hitPulse, passPulse, hiScore);
`else
  modport master (output start, pointY, pipeX, gapY, gapHalf, pipeEn,
                  input  score, running, frozen, gameOver, hitPulse, passPulse);
  modport slave  (input  start, pointY, pipeX, gapY, gapHalf, pipeEn,
                  output score, running, frozen, gameOver, hitPulse, passPulse);
`endif
endinterface

// File: rtl/pipe_collision_scorer.sv
// Pipe pass/collision detection, score keeping and IDLE/RUN/HIT/OVER sequencing.
// Define HIGH_SCORE_EN to add a best-score register on the hiScore output.
module pipe_collision_scorer #(
  parameter logic [9:0] BIRD_X    = 10'd120,
  parameter logic [9:0] BIRD_H    = 10'd24,
  parameter logic [9:0] PIPE_W    = 10'd52,
  parameter logic [9:0] FLOOR_Y   = 10'd440,
  parameter logic [9:0] MAX_SCORE = 10'd999,
  parameter logic [7:0] HIT_TICKS = 8'd60
) (
  input logic                    animationCLOCK,
  input logic                    resetN,
  pipe_collision_scorer_if.slave bus
);

  localparam int unsigned W  = 10;
  localparam int unsigned SW = W + 1;
  localparam int unsigned NP = 3;

  localparam logic [SW-1:0] BIRD_L = SW'(BIRD_X);
  localparam logic [SW-1:0] BIRD_R = SW'(BIRD_X) + SW'(BIRD_H);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HIT, ST_OVER} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   score_q, score_d;
  logic [NP-1:0]  passed_q, passed_d;
  logic [7:0]     hit_cnt_q, hit_cnt_d;
  logic           running_q, frozen_q, over_q, hit_pulse_q, pass_pulse_q;
  logic           hit_pulse_d, pass_pulse_d;

  logic [NP-1:0]  hit_vec, pass_vec, behind_vec;
  logic [SW-1:0]  bird_bot;
  logic           floor_hit, hit_any;
  logic [1:0]     pass_cnt;
  logic [SW-1:0]  score_sum;
  logic [W-1:0]   score_sat;

  assign bird_bot  = SW'(bus.pointY) + SW'(BIRD_H);
  assign floor_hit = bird_bot >= SW'(FLOOR_Y);

  // Per-pipe geometry: overlap with the square bird box, gap test, pass test
  for (genvar gi = 0; gi < NP; gi++) begin : g_pipe
    logic [W-1:0]  px, gy, gap_lo;
    logic [SW-1:0] px_end, gap_hi;
    logic          overlap;

    assign px      = bus.pipeX[gi*W +: W];
    assign gy      = bus.gapY[gi*W +: W];
    assign px_end  = SW'(px) + SW'(PIPE_W);
    assign gap_lo  = (gy > bus.gapHalf) ? gy - bus.gapHalf : '0;
    assign gap_hi  = SW'(gy) + SW'(bus.gapHalf);
    assign overlap = bus.pipeEn[gi] && (SW'(px) < BIRD_R) && (px_end > BIRD_L);

    assign hit_vec[gi]    = overlap && ((bus.pointY < gap_lo) || (bird_bot > gap_hi));
    assign behind_vec[gi] = bus.pipeEn[gi] && (px_end <= BIRD_L);
    assign pass_vec[gi]   = behind_vec[gi] && !passed_q[gi];
  end

  assign hit_any   = (|hit_vec) || floor_hit;
  assign pass_cnt  = 2'(pass_vec[0]) + 2'(pass_vec[1]) + 2'(pass_vec[2]);
  assign score_sum = SW'(score_q) + SW'(pass_cnt);
  assign score_sat = (score_sum > SW'(MAX_SCORE)) ? MAX_SCORE : score_sum[W-1:0];

  // Next-state, score and pulse logic
  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    passed_d     = passed_q;
    hit_cnt_d    = hit_cnt_q;
    hit_pulse_d  = 1'b0;
    pass_pulse_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (bus.start) begin
          state_d  = ST_RUN;
          score_d  = '0;
          passed_d = '0;
        end
      end
      ST_RUN: begin
        if (hit_any) begin
          state_d     = ST_HIT;
          hit_cnt_d   = '0;
          hit_pulse_d = 1'b1;
        end else begin
          // a pipe stays marked only while it remains enabled and behind the bird
          passed_d     = (passed_q | pass_vec) & behind_vec;
          score_d      = score_sat;
          pass_pulse_d = (score_sat != score_q);
        end
      end
      ST_HIT: begin
        if (hit_cnt_q == HIT_TICKS - 8'd1) state_d = ST_OVER;
        else                               hit_cnt_d = hit_cnt_q + 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge animationCLOCK or negedge resetN) begin
    if (!resetN) begin
      state_q      <= ST_IDLE;
      score_q      <= '0;
      passed_q     <= '0;
      hit_cnt_q    <= '0;
      running_q    <= 1'b0;
      frozen_q     <= 1'b0;
      over_q       <= 1'b0;
      hit_pulse_q  <= 1'b0;
      pass_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      passed_q     <= passed_d;
      hit_cnt_q    <= hit_cnt_d;
      running_q    <= (state_d == ST_RUN);
      frozen_q     <= (state_d == ST_HIT);
      over_q       <= (state_d == ST_OVER);
      hit_pulse_q  <= hit_pulse_d;
      pass_pulse_q <= pass_pulse_d;
    end
  end

  assign bus.score     = score_q;
  assign bus.running   = running_q;
  assign bus.frozen    = frozen_q;
  assign bus.gameOver  = over_q;
  assign bus.hitPulse  = hit_pulse_q;
  assign bus.passPulse = pass_pulse_q;

`ifdef HIGH_SCORE_EN
  logic [W-1:0] hi_q, hi_d;

  // Best score latched on the HIT->OVER edge; only resetN clears it
  always_comb begin
    hi_d = hi_q;
    if (state_q == ST_HIT && state_d == ST_OVER && score_q > hi_q) hi_d = score_q;
  end

  always_ff @(posedge animationCLOCK or negedge resetN) begin
    if (!resetN) hi_q <= '0;
    else         hi_q <= hi_d;
  end

  assign bus.hiScore = hi_q;
`endif

endmodule
